dp_app_ram_ldr: RTL and testbench



---
 rtl/prt_dp_app_ram_ldr_pkg.sv | 29 ++
 rtl/dp_app_ram_ldr.sv | 188 ++++++++++++++++++
 tb/tb_dp_app_ram_ldr.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prt_dp_app_ram_ldr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prt_dp_app_ram_ldr_pkg
// Description : Shared constants and types for the DP application RAM
//               frame loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prt_dp_app_ram_ldr_pkg;

    // Frame start marker; only recognised while idle
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4
    } ldr_state_t;

    // Sticky error codes reported on STA_ERR_OUT
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dp_app_ram_ldr.sv
`default_nettype none
// ============================================================================
// Module      : dp_app_ram_ldr
// Description : Byte-stream frame loader for the DP application RAM init
//               port. Parses A5/LEN/data/CHK frames, assembles little-endian
//               words and emits INIT start/data/valid strobes.
//               Optional inter-byte timeout: DP_APP_RAM_LDR_TIMEOUT_EN.
//               The length register holds P_ADR-1 bits of LEN, so P_ADR<=17.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_app_ram_ldr
    import prt_dp_app_ram_ldr_pkg::*;
#(
    parameter int P_ADR     = 10,
    parameter int P_TIMEOUT = 50000
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic [7:0]  LDR_DAT_IN,
    input  logic        LDR_VLD_IN,
    output logic        INIT_STR_OUT,
    output logic [31:0] INIT_DAT_OUT,
    output logic        INIT_VLD_OUT,
    output logic        STA_BUSY_OUT,
    output logic        STA_DONE_OUT,
    output logic [1:0]  STA_ERR_OUT
);

    localparam int unsigned DEPTH = 32'd1 << (P_ADR - 2);
    localparam int          CW    = P_ADR - 1;

    ldr_state_t    state, state_nxt;
    logic [CW-1:0] len,   len_nxt;
    logic [CW-1:0] cnt,   cnt_nxt;
    logic [1:0]    idx,   idx_nxt;
    logic [7:0]    acc,   acc_nxt;
    logic [7:0]    len_l, len_l_nxt;
    logic [23:0]   wbuf,  wbuf_nxt;
    logic          str,   str_nxt;
    logic          vld,   vld_nxt;
    logic [31:0]   dat,   dat_nxt;
    logic          busy,  busy_nxt;
    logic          done,  done_nxt;
    logic [1:0]    err,   err_nxt;

    logic [15:0]   len_full;
    logic [CW-1:0] cnt_inc;

    assign len_full = {LDR_DAT_IN, len_l};
    assign cnt_inc  = cnt + 1'b1;

`ifdef DP_APP_RAM_LDR_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT + 1);
    logic [TW-1:0] tmo, tmo_nxt;

    // Idle-cycle counter register
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) tmo <= '0;
        else         tmo <= tmo_nxt;
    end
`endif

    // State and datapath registers; every output is driven from here
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            idx   <= '0;
            acc   <= '0;
            len_l <= '0;
            wbuf  <= '0;
            str   <= 1'b0;
            vld   <= 1'b0;
            dat   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= ERR_NONE;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            acc   <= acc_nxt;
            len_l <= len_l_nxt;
            wbuf  <= wbuf_nxt;
            str   <= str_nxt;
            vld   <= vld_nxt;
            dat   <= dat_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Frame parser: next state, word assembly, checksum and status
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        acc_nxt   = acc;
        len_l_nxt = len_l;
        wbuf_nxt  = wbuf;
        str_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        dat_nxt   = dat;
        busy_nxt  = busy;
        done_nxt  = done;
        err_nxt   = err;
`ifdef DP_APP_RAM_LDR_TIMEOUT_EN
        tmo_nxt   = '0;
`endif
        if (LDR_VLD_IN) begin
            case (state)
                IDLE: begin
                    if (LDR_DAT_IN == SYNC_BYTE) begin
                        done_nxt  = 1'b0;
                        err_nxt   = ERR_NONE;
                        busy_nxt  = 1'b1;
                        state_nxt = LEN0;
                    end
                end
                LEN0: begin
                    len_l_nxt = LDR_DAT_IN;
                    state_nxt = LEN1;
                end
                LEN1: begin
                    if ((len_full == 16'd0) || (32'(len_full) > DEPTH)) begin
                        err_nxt   = ERR_LEN;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        len_nxt   = len_full[CW-1:0];
                        str_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        acc_nxt   = '0;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    acc_nxt = acc + LDR_DAT_IN;
                    idx_nxt = idx + 1'b1;
                    case (idx)
                        2'd0: wbuf_nxt[7:0]   = LDR_DAT_IN;
                        2'd1: wbuf_nxt[15:8]  = LDR_DAT_IN;
                        2'd2: wbuf_nxt[23:16] = LDR_DAT_IN;
                        default: begin
                            dat_nxt = {LDR_DAT_IN, wbuf};
                            vld_nxt = 1'b1;
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == len) state_nxt = CHK;
                        end
                    endcase
                end
                CHK: begin
                    if (8'(acc + LDR_DAT_IN) != 8'd0) err_nxt  = ERR_CHK;
                    else                              done_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
`ifdef DP_APP_RAM_LDR_TIMEOUT_EN
        else if (busy) begin
            // A stalled frame is abandoned without emitting its partial word
            if (tmo == TW'(P_TIMEOUT - 1)) begin
                err_nxt   = ERR_TMO;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end else begin
                tmo_nxt = tmo + 1'b1;
            end
        end
`endif
    end

    assign INIT_STR_OUT = str;
    assign INIT_DAT_OUT = dat;
    assign INIT_VLD_OUT = vld;
    assign STA_BUSY_OUT = busy;
    assign STA_DONE_OUT = done;
    assign STA_ERR_OUT  = err;

endmodule
`default_nettype wire

// File: tb/tb_dp_app_ram_ldr.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_app_ram_ldr
// Description : Scoreboard bench for dp_app_ram_ldr. Stimulus queues the
//               expected STR / VLD / frame-end events; a negedge monitor
//               pops and compares them as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_app_ram_ldr;

    localparam int P_ADR     = 10;
    localparam int P_TIMEOUT = 100;
    localparam int DEPTH     = 1 << (P_ADR - 2);

    localparam int EV_STR = 0;
    localparam int EV_VLD = 1;
    localparam int EV_END = 2;

    typedef struct {
        int          kind;
        logic [31:0] dat;
        logic        done;
        logic [1:0]  err;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ldr_dat = 8'h00;
    logic        ldr_vld = 1'b0;
    logic        str;
    logic [31:0] dat;
    logic        vld;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    logic prev_busy = 1'b0;
    logic prev_str  = 1'b0;
    logic zero_req   = 1'b0;
    logic busy_req   = 1'b0;
    logic finish_req = 1'b0;

    dp_app_ram_ldr #(.P_ADR(P_ADR), .P_TIMEOUT(P_TIMEOUT)) dut (
        .CLK_IN      (clk),
        .RST_IN      (rst),
        .LDR_DAT_IN  (ldr_dat),
        .LDR_VLD_IN  (ldr_vld),
        .INIT_STR_OUT(str),
        .INIT_DAT_OUT(dat),
        .INIT_VLD_OUT(vld),
        .STA_BUSY_OUT(busy),
        .STA_DONE_OUT(done),
        .STA_ERR_OUT (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    task automatic expect_ev(input int kind, input logic [31:0] d,
                             input logic dn, input logic [1:0] e);
        ev_t ev;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d dat=%h done=%b err=%0d, required no event",
                     kind, d, dn, e);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != kind ||
                (kind == EV_VLD && ev.dat != d) ||
                (kind == EV_END && (ev.done != dn || ev.err != e))) begin
                fails++;
                $display("FAIL event_%0d @%0t: got kind=%0d dat=%h done=%b err=%0d, required kind=%0d dat=%h done=%b err=%0d",
                         tests, $time, kind, d, dn, e, ev.kind, ev.dat, ev.done, ev.err);
            end
        end
    endtask

    always @(negedge clk) begin
        if (zero_req) begin
            tests++;
            if (str !== 1'b0 || vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                err !== 2'd0 || dat !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs: got str=%b vld=%b busy=%b done=%b err=%0d dat=%h, required all 0",
                         str, vld, busy, done, err, dat);
            end
        end
        if (busy_req) begin
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL busy_hold: got busy=%b, required 1", busy);
            end
        end
        if (str === 1'b1) expect_ev(EV_STR, 32'h0, 1'b0, 2'd0);
        if (vld === 1'b1) begin
            expect_ev(EV_VLD, dat, 1'b0, 2'd0);
            tests++;
            if (prev_str) begin
                fails++;
                $display("FAIL str_vld_adjacent: got vld=1 right after str=1, required gap");
            end
        end
        if (prev_busy === 1'b1 && busy === 1'b0) expect_ev(EV_END, 32'h0, done, err);
        prev_busy = busy;
        prev_str  = (str === 1'b1);
        if (finish_req) begin
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] d,
                        input logic dn, input logic [1:0] e);
        ev_t ev;
        ev.kind = kind;
        ev.dat  = d;
        ev.done = dn;
        ev.err  = e;
        exp_q.push_back(ev);
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        ldr_dat = b;
        ldr_vld = 1'b1;
        tick();
        ldr_vld = 1'b0;
    endtask

    task automatic pulse_req_zero();
        zero_req = 1'b1;
        @(negedge clk);
        #1 zero_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pulse_req_zero();
        tick();
    endtask

    // Complete frame: header, the given words, checksum plus chk_err offset
    task automatic frame(input int n, input logic [31:0] ws[$],
                         input logic [7:0] chk_err, input int maxgap);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        if (n == 0 || n > DEPTH) begin
            push(EV_END, 32'h0, 1'b0, 2'd1);
            put(8'hA5, $urandom_range(maxgap, 0));
            put(n[7:0], $urandom_range(maxgap, 0));
            put(n[15:8], $urandom_range(maxgap, 0));
            return;
        end
        push(EV_STR, 32'h0, 1'b0, 2'd0);
        put(8'hA5, $urandom_range(maxgap, 0));
        put(n[7:0], $urandom_range(maxgap, 0));
        put(n[15:8], $urandom_range(maxgap, 0));
        foreach (ws[i]) begin
            push(EV_VLD, ws[i], 1'b0, 2'd0);
            for (int k = 0; k < 4; k++) begin
                b = ws[i][8*k +: 8];
                sum = sum + b;
                put(b, $urandom_range(maxgap, 0));
            end
        end
        if (chk_err == 8'h00) push(EV_END, 32'h0, 1'b1, 2'd0);
        else                  push(EV_END, 32'h0, 1'b0, 2'd2);
        put(8'(8'h00 - sum + chk_err), $urandom_range(maxgap, 0));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] ws[$];
        logic [7:0]  junk;
        int          n;
        logic [7:0]  cerr;

        repeat (3) tick();
        rst = 1'b1;
        pulse_req_zero();
        tick();

        // Single word with correct checksum (C8)
        ws = {32'hDEADBEEF};
        frame(1, ws, 8'h00, 0);
        repeat (3) tick();

        // Length beyond depth
        ws = {};
        frame(257, ws, 8'h00, 0);
        repeat (3) tick();

        // Zero length
        frame(0, ws, 8'h00, 1);
        repeat (3) tick();

        // Bad checksum: checksum byte 00 instead of C8
        ws = {32'hDEADBEEF};
        frame(1, ws, 8'h38, 0);
        repeat (3) tick();

        // Stalled frame after two data bytes
        push(EV_STR, 32'h0, 1'b0, 2'd0);
        put(8'hA5, 0); put(8'h01, 0); put(8'h00, 0); put(8'hEF, 0); put(8'hBE, 0);
`ifdef DP_APP_RAM_LDR_TIMEOUT_EN
        push(EV_END, 32'h0, 1'b0, 2'd3);
        repeat (P_TIMEOUT + 10) tick();
`else
        repeat (P_TIMEOUT + 50) tick();
        busy_req = 1'b1;
        @(negedge clk);
        #1 busy_req = 1'b0;
        push(EV_END, 32'h0, 1'b0, 2'd0);
        do_reset();
`endif

        // Resync and full-depth back-to-back load
        put(8'h00, 0);
        put(8'hFF, 0);
        ws = {};
        for (int i = 0; i < DEPTH; i++)
            ws.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        frame(DEPTH, ws, 8'h00, 0);
        repeat (3) tick();

        // Reset mid-DATA after two words
        push(EV_STR, 32'h0, 1'b0, 2'd0);
        push(EV_VLD, 32'h44332211, 1'b0, 2'd0);
        push(EV_VLD, 32'h88776655, 1'b0, 2'd0);
        push(EV_END, 32'h0, 1'b0, 2'd0);
        put(8'hA5, 0); put(8'h03, 0); put(8'h00, 0);
        for (int i = 1; i <= 8; i++) put(8'(8'h11 * i), 0);
        do_reset();
        ws = {32'hDEADBEEF};
        frame(1, ws, 8'h00, 0);
        repeat (3) tick();

        // Randomized frames with junk, gaps, bad lengths and bad checksums
        for (int f = 0; f < 40; f++) begin
            for (int j = $urandom_range(2, 0); j > 0; j--) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                put(junk, $urandom_range(2, 0));
            end
            ws = {};
            if ($urandom_range(9, 0) < 2) begin
                n = ($urandom_range(1, 0) == 0) ? 0 : DEPTH + 1 + $urandom_range(300, 0);
            end else begin
                n = $urandom_range(6, 1);
                for (int i = 0; i < n; i++) ws.push_back($urandom);
            end
            cerr = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            frame(n, ws, cerr, 3);
            repeat ($urandom_range(3, 1)) tick();
        end

        repeat (5) tick();
        finish_req = 1'b1;
    end

    // Global bound on simulation time
    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
